// File: rtl/issue_ctrl_pkg.sv
// Shared decoder constants for the issue stage:
// unit select encoding, op-bus bit selections and slot states.
package issue_ctrl_pkg;

    localparam int DEC_OPB_SIZE = 16;
    localparam int DEC_USELE    = 3;

    localparam int USE_ALU = 0;
    localparam int USE_BJU = 1;
    localparam int USE_AGU = 2;

    localparam int BJU_JAL  = 0;
    localparam int BJU_JALR = 1;
    localparam int BJU_BEQ  = 2;

    // LB, LH, LW, LBU, LHU occupy the low five AGU op bits
    localparam logic [DEC_OPB_SIZE-1:0] LSU_LOAD_MASK = 16'h001F;
    localparam logic [DEC_OPB_SIZE-1:0] LSU_LW        = 16'h0004;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_TRAP  = 2'd2
    } issue_st_e;

    // Does the held instruction write a destination register?
    function automatic logic rd_wen(
        input logic [DEC_USELE-1:0]    usele,
        input logic [DEC_OPB_SIZE-1:0] opb
    );
        return usele[USE_ALU]
            | (usele[USE_BJU] & (opb[BJU_JAL] | opb[BJU_JALR]))
            | (usele[USE_AGU] & (|(opb & LSU_LOAD_MASK)));
    endfunction

endpackage

// File: rtl/issue_scbd.sv
// Register busy scoreboard for x1..x31 with writeback bypass
// on the read ports; a same-index set beats a clear.
module issue_scbd
    import issue_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_set_val,
    input  logic [4:0] i_set_idx,
    input  logic       i_clr_val,
    input  logic [4:0] i_clr_idx,
    input  logic [4:0] i_rd0_idx,
    input  logic [4:0] i_rd1_idx,
    input  logic [4:0] i_rd2_idx,
    output logic       o_rd0_busy,
    output logic       o_rd1_busy,
    output logic       o_rd2_busy
);

    logic [31:1] busy_q;
    logic [31:1] busy_d;
    logic [31:0] busy_v;

    // Read view: x0 hard zero, writeback clear seen same cycle
    always_comb begin
        busy_v = {busy_q, 1'b0};
        if (i_clr_val) busy_v[i_clr_idx] = 1'b0;
        busy_v[0] = 1'b0;
        o_rd0_busy = busy_v[i_rd0_idx];
        o_rd1_busy = busy_v[i_rd1_idx];
        o_rd2_busy = busy_v[i_rd2_idx];
    end

    // Next busy vector: clear first, set overrides
    always_comb begin
        busy_d = busy_q;
        for (int k = 1; k < 32; k++) begin
            if (i_set_val && i_set_idx == 5'(k))
                busy_d[k] = 1'b1;
            else if (i_clr_val && i_clr_idx == 5'(k))
                busy_d[k] = 1'b0;
        end
    end

    // Busy register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) busy_q <= '0;
        else          busy_q <= busy_d;
    end

endmodule

// File: rtl/issue_ctrl.sv
// Single-entry issue slot: holds one decoded instruction, checks
// register hazards and hands it to the ALU, BJU or AGU.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int OPBW = DEC_OPB_SIZE
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_dec_val,
    output logic                 o_dec_rdy,
    input  logic [DEC_USELE-1:0] i_usele,
    input  logic [OPBW-1:0]      i_opb,
    input  logic                 i_rs1_ren,
    input  logic                 i_rs2_ren,
    input  logic [4:0]           i_rs1_idx,
    input  logic [4:0]           i_rs2_idx,
    input  logic [4:0]           i_rd_idx,
    input  logic [31:0]          i_im,
    input  logic [31:0]          i_pc,
    input  logic                 i_ilgl,
    input  logic                 i_flush,
    output logic                 o_alu_val,
    input  logic                 i_alu_rdy,
    output logic                 o_bju_val,
    input  logic                 i_bju_rdy,
    output logic                 o_agu_val,
    input  logic                 i_agu_rdy,
    output logic [OPBW-1:0]      o_opb,
    output logic [4:0]           o_rs1_idx,
    output logic [4:0]           o_rs2_idx,
    output logic [4:0]           o_rd_idx,
    output logic [31:0]          o_im,
    output logic [31:0]          o_pc,
    input  logic                 i_wb_val,
    input  logic [4:0]           i_wb_idx,
    output logic                 o_trap_val,
    output logic [31:0]          o_trap_pc,
    input  logic                 i_trap_ack,
    output logic [15:0]          o_stall_cnt
);

    issue_st_e st_q, st_d;

    logic [DEC_USELE-1:0] usele_q;
    logic                 rs1_ren_q, rs2_ren_q;
    logic                 rs1_busy, rs2_busy, rd_busy;
    logic                 wen, hazard, fire, accept;
    logic [2:0]           issue;

    assign wen = rd_wen(usele_q, DEC_OPB_SIZE'(o_opb));
    assign hazard = (rs1_ren_q & rs1_busy)
                  | (rs2_ren_q & rs2_busy)
                  | (wen & rd_busy);

    issue_scbd u_scbd (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_set_val  (fire & wen),
        .i_set_idx  (o_rd_idx),
        .i_clr_val  (i_wb_val),
        .i_clr_idx  (i_wb_idx),
        .i_rd0_idx  (o_rs1_idx),
        .i_rd1_idx  (o_rs2_idx),
        .i_rd2_idx  (o_rd_idx),
        .o_rd0_busy (rs1_busy),
        .o_rd1_busy (rs2_busy),
        .o_rd2_busy (rd_busy)
    );

    // Slot state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) st_q <= ST_EMPTY;
        else          st_q <= st_d;
    end

    // Next state, issue handshake and decoder ready
    always_comb begin
        st_d       = st_q;
        issue      = 3'b000;
        fire       = 1'b0;
        o_dec_rdy  = 1'b0;
        accept     = 1'b0;
        o_trap_val = 1'b0;
        unique case (st_q)
            ST_EMPTY, ST_FULL: begin
                if (st_q == ST_FULL && !i_flush && !hazard)
                    issue = usele_q;
                fire = |(issue & {i_agu_rdy, i_bju_rdy, i_alu_rdy});
                o_dec_rdy = !i_flush && (st_q == ST_EMPTY || fire);
                accept = i_dec_val & o_dec_rdy;
                if (i_flush)
                    st_d = ST_EMPTY;
                else if (accept)
                    st_d = i_ilgl ? ST_TRAP
                         : (i_usele == '0) ? ST_EMPTY : ST_FULL;
                else if (fire)
                    st_d = ST_EMPTY;
            end
            ST_TRAP: begin
                o_trap_val = 1'b1;
                if (i_trap_ack) st_d = ST_EMPTY;
            end
            default: st_d = ST_EMPTY;
        endcase
        o_alu_val = issue[USE_ALU];
        o_bju_val = issue[USE_BJU];
        o_agu_val = issue[USE_AGU];
    end

    // Payload capture on a legal, unit-bound accept
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            usele_q   <= '0;
            rs1_ren_q <= 1'b0;
            rs2_ren_q <= 1'b0;
            o_opb     <= '0;
            o_rs1_idx <= '0;
            o_rs2_idx <= '0;
            o_rd_idx  <= '0;
            o_im      <= '0;
            o_pc      <= '0;
        end else if (accept && !i_ilgl && i_usele != '0) begin
            usele_q   <= i_usele;
            rs1_ren_q <= i_rs1_ren;
            rs2_ren_q <= i_rs2_ren;
            o_opb     <= i_opb;
            o_rs1_idx <= i_rs1_idx;
            o_rs2_idx <= i_rs2_idx;
            o_rd_idx  <= i_rd_idx;
            o_im      <= i_im;
            o_pc      <= i_pc;
        end
    end

    // Trap pc capture on an illegal accept
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                o_trap_pc <= '0;
        else if (accept && i_ilgl)   o_trap_pc <= i_pc;
    end

    // Saturating count of hazard-stalled cycles
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_stall_cnt <= '0;
        else if (st_q == ST_FULL && hazard && o_stall_cnt != 16'hFFFF)
            o_stall_cnt <= o_stall_cnt + 16'd1;
    end

endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 SHALL have parameter OPBW, default `CIRNO_DEC_OPB_SIZE, meaning width of the operation bus.
REQ-002 SHALL have ports, one clock and one reset, asynchronous active-low:
  i_clk  in  1  core clock
  i_rst_n  in  1  asynchronous active-low reset
  i_dec_val  in  1  decoded instruction valid
  o_dec_rdy  out  1  issue register can accept
  i_usele  in  `CIRNO_DEC_USELE  unit select, one-hot ALU/BJU/AGU
  i_opb  in  OPBW  operation bus
  i_rs1_ren, i_rs2_ren  in  1 each  source read enables
  i_rs1_idx, i_rs2_idx, i_rd_idx  in  5 each  register indices
  i_im, i_pc  in  32 each  immediate, pc
  i_ilgl  in  1  illegal instruction
  i_flush  in  1  discard held instruction
  o_alu_val/i_alu_rdy, o_bju_val/i_bju_rdy, o_agu_val/i_agu_rdy  out/in  1 each  per-unit handshake
  o_opb  out  OPBW; o_rs1_idx, o_rs2_idx, o_rd_idx  out  5 each; o_im, o_pc  out  32 each  shared issue payload
  i_wb_val  in  1; i_wb_idx  in  5  writeback, releases scoreboard bit
  o_trap_val  out  1; o_trap_pc  out  32; i_trap_ack  in  1  illegal-instruction trap handshake
  o_stall_cnt  out  16  hazard-stall counter

Function
REQ-003 SHALL hold one instruction in a registered issue slot; states EMPTY, FULL, TRAP.
REQ-004 SHALL drive o_dec_rdy = (EMPTY) | (FULL & issue fires this cycle) with no flush; never in TRAP.
REQ-005 SHALL, on accept (i_dec_val & o_dec_rdy) with i_ilgl=1, go to TRAP, latch i_pc into o_trap_pc, assert o_trap_val next cycle.
REQ-006 SHALL, on accept with i_usele==0 and i_ilgl=0, discard the instruction (state EMPTY).
REQ-007 SHALL otherwise register payload and go FULL; o_*_val earliest one cycle after accept.
REQ-008 SHALL assert exactly one o_*_val, per held usele, only when FULL and no hazard.
REQ-009 Hazard SHALL be: (rs1_ren & rs1_idx!=0 & busy[rs1]) | (rs2_ren & rs2_idx!=0 & busy[rs2]) | (wen & rd_idx!=0 & busy[rd]).
REQ-010 wen SHALL be 1 for ALU, for BJU with opb JAL or JALR bit, for AGU with any LSU load bit; 0 otherwise.
REQ-011 busy SHALL be a 31-bit scoreboard (x1..x31); x0 never busy.
REQ-012 i_wb_val SHALL clear busy[i_wb_idx] and be visible to hazard check the same cycle (bypass).
REQ-013 Issue fire (o_*_val & matching rdy) SHALL set busy[rd] when wen; simultaneous set and clear of same index: set wins.
REQ-014 Fire with no new accept SHALL go EMPTY; fire with accept SHALL stay FULL with new payload (back-to-back, one per cycle).
REQ-015 Payload SHALL remain stable while o_*_val high and rdy low.
REQ-016 i_flush SHALL force EMPTY next cycle, suppress this cycle's accept and issue; scoreboard unchanged; ignored in TRAP.
REQ-017 TRAP SHALL persist until i_trap_ack, then EMPTY; o_trap_val deasserts the cycle after ack.
REQ-018 o_stall_cnt SHALL increment once per cycle FULL & hazard, saturating at 16'hFFFF.

Reset
REQ-019 i_rst_n low SHALL immediately force state EMPTY, busy=0, o_*_val=0, o_trap_val=0, o_trap_pc=0, o_stall_cnt=0, payload outputs 0, regardless of in-flight handshakes.
REQ-020 o_dec_rdy SHALL be 1 in the first cycle after reset release.

Structure
REQ-021 State encodings and the LSU-load/JAL/JALR bit selections SHALL live in cirno9_define.v alongside existing decoder constants.
REQ-022 The scoreboard SHALL be a sub-module issue_scbd (set port, clear port, three read ports).

Verification
REQ-023 Back-to-back independent: addi x1; addi x2; i_alu_rdy=1 -> o_alu_val two consecutive cycles, o_rd_idx 1 then 2, o_stall_cnt=0.
REQ-024 RAW: lw x5 issued, add x6,x5,x5 follows, writeback x5 after 3 cycles -> add stalls, o_stall_cnt=3, add issues the cycle i_wb_val/i_wb_idx=5 asserts.
REQ-025 Backpressure: addi x3 with i_alu_rdy=0 for 4 cycles -> payload constant, o_dec_rdy=0, busy[3] set only on firing cycle.
REQ-026 Illegal: i_ilgl=1, i_pc=32'h80 -> o_trap_val=1, o_trap_pc=32'h80, o_dec_rdy=0 until i_trap_ack, then EMPTY.
REQ-027 Flush/reset: FULL with hazard, i_flush=1 -> EMPTY, busy unchanged; then i_rst_n low mid-issue -> all outputs 0, busy=0.
REQ-028 x0 and branch: add x0,...; beq x0,x0 -> no busy bits set, no stalls.
